reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement stage directly downstream of the execute stage.
- Issue allocates an entry per instruction in program order.
- Execute results (rd data, branch outcome, next pc) return out of order, tagged with the entry index.
- Entries commit in order to the register file. A branch resolving to a non-fall-through target squashes all younger entries and redirects fetch.

Parameters:
- ROB_SIZE_LOG, 2, log2 of entry count (4 entries); defined in param.v.
- MEMI_SIZE_LOG, REG_LEN, RF_SIZE_LOG: existing param.v macros for pc width, data width and register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  issue presents an instruction
- alloc_ready  out  1  entry available
- alloc_pc  in  MEMI_SIZE_LOG  instruction pc
- alloc_rd  in  RF_SIZE_LOG  destination register
- alloc_wen  in  1  instruction writes rd
- alloc_is_br  in  1  instruction is a branch
- alloc_tag  out  ROB_SIZE_LOG  index given to the allocated entry (current tail)
- wb_valid  in  1  execute result valid
- wb_tag  in  ROB_SIZE_LOG  entry being completed
- wb_rd_data  in  REG_LEN  execute rd_data
- wb_next_pc  in  MEMI_SIZE_LOG  execute next_pc
- commit_valid  out  1  head entry retiring this cycle
- commit_rd  out  RF_SIZE_LOG  retiring destination
- commit_wen  out  1  register file write enable (commit_valid & entry wen)
- commit_data  out  REG_LEN  retiring data
- squash  out  1  flush younger entries and redirect fetch
- squash_pc  out  MEMI_SIZE_LOG  redirect target
- empty  out  1  no valid entries
- full  out  1  all entries valid

Behaviour:
- Storage per entry: valid, done, pc, rd, wen, is_br, data, next_pc.
- Pointers: head and tail are ROB_SIZE_LOG+1 bits, the MSB being the wrap bit.
  - empty = (head==tail).
  - full = index bits equal and wrap bits differ.
- Reset (async, rst_n=0): head=tail=0; all valid/done cleared; every output 0 except alloc_ready=1 and empty=1. Asserting reset mid-operation discards all entries immediately.
- Allocate on alloc_valid & alloc_ready at the clock edge: entry[tail] gets valid=1, done=0 and the alloc fields; tail increments mod 2^(ROB_SIZE_LOG+1).
  - alloc_ready = !full & !squash. It does not depend on a same-cycle commit.
- Writeback on wb_valid at the clock edge: if entry[wb_tag].valid & !done, set done=1 and store wb_rd_data and wb_next_pc.
  - Writeback to an invalid or already-done entry is ignored.
- Commit is combinational from head state: commit_valid = entry[head].valid & entry[head].done.
  - Minimum latency is one cycle from the writeback edge to commit_valid.
  - A writeback to the head entry is not bypassed to commit in the same cycle.
- On commit the head entry is cleared and head increments.
- Commit outputs other than commit_valid are 0 when commit_valid=0.
- Branch resolution at commit: if is_br & next_pc != pc+1 (mod 2^MEMI_SIZE_LOG), then squash=1 and squash_pc=next_pc in that cycle.
  - The branch itself commits; commit_wen=0 for branches.
  - At the edge, every valid entry is cleared and tail is set to the new head, so the ROB is empty on the next cycle.
  - An allocation offered in a squash cycle is not accepted.
  - A writeback in a squash cycle is discarded.
- Simultaneous alloc + commit when not full: both occur and the count is unchanged.
- Simultaneous alloc + writeback to the same tag: allocation happens, writeback is ignored (entry was not yet valid).
- Wrap-around: index bits wrap modulo 2^ROB_SIZE_LOG; the wrap bit toggles.

Optional Feature:
- Macro ROB_PERF_CNT_EN.
- When defined: adds outputs perf_commit_cnt (32 bits) and perf_squash_cnt (32 bits).
  - perf_commit_cnt increments on every commit; perf_squash_cnt increments on every squash cycle.
  - Both reset to 0 asynchronously and wrap at 2^32.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- param.v (shared) gains ROB_SIZE_LOG and ROB_SIZE.
- One natural sub-module, rob_entry: a single entry's registers with alloc/wb/clear write ports, instantiated ROB_SIZE times.
- Pointer and commit/squash logic stays in reorder_buffer.

Test Plan:
- Reset with 2 entries allocated, then rst_n=0 → empty=1, alloc_ready=1, commit_valid=0, squash=0 immediately.
- Allocate pcs 0,1,2,3 (rd 1..4, wen=1) → tags 0,1,2,3, full=1, alloc_ready=0. Writeback order 2,0,3,1 with data 0x20,0x00,0x30,0x10 → commits rd1,rd2,rd3,rd4 in order, the first commit one cycle after the tag-0 writeback, with data matching each tag.
- Branch at pc=5 (tag 0) plus two younger entries; writeback next_pc=9 → at commit squash=1, squash_pc=9, commit_wen=0; next cycle empty=1, and the younger entries never produce commit_valid.
- Branch at pc=5 with writeback next_pc=6 → no squash; the younger entry commits normally.
- Fill, commit one, allocate one across the index boundary, repeated 10 times → tags cycle 0,1,2,3,0…; full/empty correct at each step.
- Writeback to a non-allocated tag, and a duplicate writeback carrying different data → both ignored; the committed data equals the first valid writeback.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared sizes, entry record and pointer helper for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_LOG  = 2;
  localparam int ROB_SIZE      = 1 << ROB_SIZE_LOG;
  localparam int MEMI_SIZE_LOG = 8;
  localparam int REG_LEN       = 32;
  localparam int RF_SIZE_LOG   = 5;
  localparam int PTR_W         = ROB_SIZE_LOG + 1;

  typedef struct packed {
    logic                     valid;
    logic                     done;
    logic [MEMI_SIZE_LOG-1:0] pc;
    logic [RF_SIZE_LOG-1:0]   rd;
    logic                     wen;
    logic                     is_br;
    logic [REG_LEN-1:0]       data;
    logic [MEMI_SIZE_LOG-1:0] next_pc;
  } rob_entry_t;

  // Pointers carry a wrap bit above the index, so a plain increment wraps both.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer entry: allocation, writeback and clear write ports.
// Clear has priority over allocate, which has priority over writeback.
module rob_entry
  import reorder_buffer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_i,
  input  logic [MEMI_SIZE_LOG-1:0] alloc_pc_i,
  input  logic [RF_SIZE_LOG-1:0]   alloc_rd_i,
  input  logic                     alloc_wen_i,
  input  logic                     alloc_is_br_i,
  input  logic                     wb_i,
  input  logic [REG_LEN-1:0]       wb_data_i,
  input  logic [MEMI_SIZE_LOG-1:0] wb_next_pc_i,
  input  logic                     clr_i,
  output rob_entry_t               entry_o
);

  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic [MEMI_SIZE_LOG-1:0] pc_q;
  logic [RF_SIZE_LOG-1:0]   rd_q;
  logic                     wen_q;
  logic                     is_br_q;
  logic [REG_LEN-1:0]       data_q;
  logic [MEMI_SIZE_LOG-1:0] next_pc_q;
  logic                     wb_accept;

  // A result only lands in an entry that is live and still waiting for it.
  assign wb_accept = wb_i & valid_q & ~done_q;

  // Next-state of the control bits.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (clr_i) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (alloc_i) begin
      valid_d = 1'b1;
      done_d  = 1'b0;
    end else if (wb_accept) begin
      done_d  = 1'b1;
    end
  end

  // Control bits are the only state that reset has to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload is only observed while valid, so it is captured without reset.
  always_ff @(posedge clk) begin
    if (alloc_i) begin
      pc_q    <= alloc_pc_i;
      rd_q    <= alloc_rd_i;
      wen_q   <= alloc_wen_i;
      is_br_q <= alloc_is_br_i;
    end
    if (wb_accept) begin
      data_q    <= wb_data_i;
      next_pc_q <= wb_next_pc_i;
    end
  end

  assign entry_o = '{valid: valid_q, done: done_q, pc: pc_q, rd: rd_q, wen: wen_q,
                     is_br: is_br_q, data: data_q, next_pc: next_pc_q};

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates in program order, accepts tagged
// out-of-order results, commits from the head and squashes on a taken branch.
// Optional macro ROB_PERF_CNT_EN adds commit/squash event counters.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [MEMI_SIZE_LOG-1:0] alloc_pc,
  input  logic [RF_SIZE_LOG-1:0]   alloc_rd,
  input  logic                     alloc_wen,
  input  logic                     alloc_is_br,
  output logic [ROB_SIZE_LOG-1:0]  alloc_tag,
  input  logic                     wb_valid,
  input  logic [ROB_SIZE_LOG-1:0]  wb_tag,
  input  logic [REG_LEN-1:0]       wb_rd_data,
  input  logic [MEMI_SIZE_LOG-1:0] wb_next_pc,
  output logic                     commit_valid,
  output logic [RF_SIZE_LOG-1:0]   commit_rd,
  output logic                     commit_wen,
  output logic [REG_LEN-1:0]       commit_data,
  output logic                     squash,
  output logic [MEMI_SIZE_LOG-1:0] squash_pc,
  output logic                     empty,
  output logic                     full
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_commit_cnt,
  output logic [31:0]              perf_squash_cnt
`endif
);

  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [ROB_SIZE_LOG-1:0]  head_idx, tail_idx;
  rob_entry_t               ent [ROB_SIZE];
  rob_entry_t               hd;
  logic                     alloc_fire;
  logic                     mispredict;
  logic [MEMI_SIZE_LOG-1:0] fall_thru;

  assign head_idx = head_q[ROB_SIZE_LOG-1:0];
  assign tail_idx = tail_q[ROB_SIZE_LOG-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[ROB_SIZE_LOG] != tail_q[ROB_SIZE_LOG]);

  // Commit is purely a function of the registered head entry: no wb bypass.
  assign hd           = ent[head_idx];
  assign commit_valid = hd.valid & hd.done;
  assign fall_thru    = hd.pc + MEMI_SIZE_LOG'(1);
  assign mispredict   = hd.is_br & (hd.next_pc != fall_thru);
  assign squash       = commit_valid & mispredict;
  assign squash_pc    = squash ? hd.next_pc : '0;
  assign commit_rd    = commit_valid ? hd.rd : '0;
  assign commit_data  = commit_valid ? hd.data : '0;
  assign commit_wen   = commit_valid & hd.wen & ~hd.is_br;

  // Squash blocks allocation so nothing new slips in behind the flush.
  assign alloc_ready = ~full & ~squash;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid & alloc_ready;

  // Pointer advance; a squash collapses tail onto the post-commit head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (commit_valid) head_d = ptr_inc(head_q);
    if (squash) tail_d = head_d;
    else if (alloc_fire) tail_d = ptr_inc(tail_q);
  end

  // Head/tail pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent
    rob_entry u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc_i      (alloc_fire && (tail_idx == ROB_SIZE_LOG'(i))),
      .alloc_pc_i   (alloc_pc),
      .alloc_rd_i   (alloc_rd),
      .alloc_wen_i  (alloc_wen),
      .alloc_is_br_i(alloc_is_br),
      .wb_i         (wb_valid && !squash && (wb_tag == ROB_SIZE_LOG'(i))),
      .wb_data_i    (wb_rd_data),
      .wb_next_pc_i (wb_next_pc),
      .clr_i        (squash || (commit_valid && (head_idx == ROB_SIZE_LOG'(i)))),
      .entry_o      (ent[i])
    );
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] commit_cnt_q, squash_cnt_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt_q <= '0;
      squash_cnt_q <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_q + 32'(commit_valid);
      squash_cnt_q <= squash_cnt_q + 32'(squash);
    end
  end

  assign perf_commit_cnt = commit_cnt_q;
  assign perf_squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued in program
// order at allocation and compared whenever the DUT retires an entry.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [MEMI_SIZE_LOG-1:0] alloc_pc;
  logic [RF_SIZE_LOG-1:0]   alloc_rd;
  logic                     alloc_wen;
  logic                     alloc_is_br;
  logic [ROB_SIZE_LOG-1:0]  alloc_tag;
  logic                     wb_valid;
  logic [ROB_SIZE_LOG-1:0]  wb_tag;
  logic [REG_LEN-1:0]       wb_rd_data;
  logic [MEMI_SIZE_LOG-1:0] wb_next_pc;
  logic                     commit_valid;
  logic [RF_SIZE_LOG-1:0]   commit_rd;
  logic                     commit_wen;
  logic [REG_LEN-1:0]       commit_data;
  logic                     squash;
  logic [MEMI_SIZE_LOG-1:0] squash_pc;
  logic                     empty;
  logic                     full;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]              perf_commit_cnt;
  logic [31:0]              perf_squash_cnt;
`endif

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_rd(alloc_rd), .alloc_wen(alloc_wen), .alloc_is_br(alloc_is_br),
    .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_rd_data(wb_rd_data), .wb_next_pc(wb_next_pc),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_wen(commit_wen),
    .commit_data(commit_data), .squash(squash), .squash_pc(squash_pc),
    .empty(empty), .full(full)
`ifdef ROB_PERF_CNT_EN
    , .perf_commit_cnt(perf_commit_cnt), .perf_squash_cnt(perf_squash_cnt)
`endif
  );

  typedef struct {
    logic [RF_SIZE_LOG-1:0]   rd;
    logic                     wen;
    logic [REG_LEN-1:0]       data;
    logic                     sq;
    logic [MEMI_SIZE_LOG-1:0] sqpc;
  } exp_t;

  exp_t               sb[$];
  exp_t               mon_e;
  int                 checks = 0;
  int                 errors = 0;
  logic [PTR_W-1:0]   exp_tail = '0;
  logic [PTR_W-1:0]   exp_head = '0;
  logic [REG_LEN-1:0] tag_data [ROB_SIZE];
  logic [ROB_SIZE_LOG-1:0] ht;
  logic [PTR_W-1:0]   start_head;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [RF_SIZE_LOG-1:0] rd, input logic wen,
                          input logic [REG_LEN-1:0] data, input logic sq,
                          input logic [MEMI_SIZE_LOG-1:0] sqpc);
    exp_t e;
    e.rd = rd; e.wen = wen; e.data = data; e.sq = sq; e.sqpc = sqpc;
    sb.push_back(e);
  endtask

  task automatic do_alloc(input logic [MEMI_SIZE_LOG-1:0] pc, input logic [RF_SIZE_LOG-1:0] rd,
                          input logic wen, input logic br, input logic [REG_LEN-1:0] data,
                          input logic push);
    tag_data[exp_tail[ROB_SIZE_LOG-1:0]] = data;
    if (push) push_exp(rd, wen & ~br, data, 1'b0, '0);
    alloc_valid = 1'b1; alloc_pc = pc; alloc_rd = rd; alloc_wen = wen; alloc_is_br = br;
    @(negedge clk);
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_tag", alloc_tag, exp_tail[ROB_SIZE_LOG-1:0]);
    step();
    alloc_valid = 1'b0;
    exp_tail = exp_tail + 1'b1;
  endtask

  task automatic do_wb(input logic [ROB_SIZE_LOG-1:0] tag, input logic [REG_LEN-1:0] data,
                       input logic [MEMI_SIZE_LOG-1:0] npc);
    wb_valid = 1'b1; wb_tag = tag; wb_rd_data = data; wb_next_pc = npc;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Retirement monitor: compare every commit against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && commit_valid) begin
      exp_head = exp_head + 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_commit", commit_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("commit_rd", commit_rd, mon_e.rd);
        chk("commit_wen", commit_wen, mon_e.wen);
        chk("commit_data", commit_data, mon_e.data);
        chk("squash", squash, mon_e.sq);
        chk("squash_pc", squash_pc, mon_e.sqpc);
      end
    end
    if (rst_n && !commit_valid && (squash || commit_wen || commit_rd != 0 || commit_data != 0))
      chk("idle_outputs_nonzero", {squash, commit_wen, commit_rd, commit_data}, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    alloc_valid = 1'b0; alloc_pc = '0; alloc_rd = '0; alloc_wen = 1'b0; alloc_is_br = 1'b0;
    wb_valid = 1'b0; wb_tag = '0; wb_rd_data = '0; wb_next_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_commit_valid", commit_valid, 0);
    rst_n = 1'b1;
    step();

    // Reset while two entries are live discards them immediately.
    do_alloc(8'd40, 5'd1, 1'b1, 1'b0, 32'h1, 1'b0);
    do_alloc(8'd41, 5'd2, 1'b1, 1'b0, 32'h2, 1'b0);
    chk("pre_rst_empty", empty, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_alloc_ready", alloc_ready, 1);
    chk("mid_rst_commit_valid", commit_valid, 0);
    chk("mid_rst_squash", squash, 0);
    chk("mid_rst_alloc_tag", alloc_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_tail = '0;
    exp_head = '0;
    step();

    // Fill, then complete out of order; commits must stay in order.
    for (int i = 0; i < 4; i++)
      do_alloc(8'(i), 5'(i + 1), 1'b1, 1'b0, 32'(i * 16), 1'b1);
    chk("fill_full", full, 1);
    chk("fill_alloc_ready", alloc_ready, 0);
    chk("fill_empty", empty, 0);
    do_wb(2'd2, 32'h20, 8'd3);
    wb_valid = 1'b1; wb_tag = 2'd0; wb_rd_data = 32'h00; wb_next_pc = 8'd1;
    @(negedge clk);
    chk("cv_same_cycle_as_wb0", commit_valid, 0);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("cv_after_wb0", commit_valid, 1);
    do_wb(2'd3, 32'h30, 8'd4);
    do_wb(2'd1, 32'h10, 8'd2);
    wait_drain();
    chk("ooo_empty", empty, 1);

    // Taken branch squashes two completed younger entries.
    push_exp(5'd0, 1'b0, 32'h0, 1'b1, 8'd9);
    do_alloc(8'd5, 5'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    do_alloc(8'd6, 5'd5, 1'b1, 1'b0, 32'h55, 1'b0);
    do_alloc(8'd7, 5'd6, 1'b1, 1'b0, 32'h66, 1'b0);
    do_wb(2'd1, 32'h55, 8'd7);
    do_wb(2'd2, 32'h66, 8'd8);
    do_wb(2'd0, 32'h0, 8'd9);
    alloc_valid = 1'b1; alloc_pc = 8'd8; alloc_rd = 5'd7; alloc_wen = 1'b1; alloc_is_br = 1'b0;
    @(negedge clk);
    chk("sq_cycle_squash", squash, 1);
    chk("sq_cycle_alloc_ready", alloc_ready, 0);
    step();
    alloc_valid = 1'b0;
    chk("post_squash_empty", empty, 1);
    chk("post_squash_full", full, 0);
    exp_tail = exp_head;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("squashed_no_commit", commit_valid, 0);
    end
    step();

    // Not-taken branch (next_pc == pc+1): no squash, younger commits.
    do_alloc(8'd5, 5'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    do_alloc(8'd6, 5'd7, 1'b1, 1'b0, 32'h77, 1'b1);
    do_wb(exp_tail[ROB_SIZE_LOG-1:0] - 2'd1, 32'h77, 8'd7);
    do_wb(exp_tail[ROB_SIZE_LOG-1:0] - 2'd2, 32'h0, 8'd6);
    wait_drain();
    chk("nt_empty", empty, 1);

    // Ignored writebacks: unallocated tag, same-cycle alloc, duplicate.
    do_wb(exp_tail[ROB_SIZE_LOG-1:0] + 2'd1, 32'hDEAD, 8'd1);
    do_alloc(8'd10, 5'd8, 1'b1, 1'b0, 32'h33, 1'b1);
    wb_valid = 1'b1; wb_tag = exp_tail[ROB_SIZE_LOG-1:0]; wb_rd_data = 32'hBAD; wb_next_pc = 8'd12;
    do_alloc(8'd11, 5'd9, 1'b1, 1'b0, 32'h44, 1'b1);
    wb_valid = 1'b0;
    do_wb(exp_tail[ROB_SIZE_LOG-1:0] - 2'd1, 32'h44, 8'd12);
    do_wb(exp_tail[ROB_SIZE_LOG-1:0] - 2'd1, 32'h55, 8'd12);
    @(negedge clk);
    chk("head_not_done_wait", commit_valid, 0);
    do_wb(exp_tail[ROB_SIZE_LOG-1:0] - 2'd2, 32'h33, 8'd11);
    wait_drain();

    // Wrap-around: keep the buffer full, retiring and refilling one at a time.
    for (int k = 0; k < 4; k++)
      do_alloc(8'(20 + k), 5'(10 + k), 1'b1, 1'b0, 32'h200 + 32'(k), 1'b1);
    chk("wrap_fill_full", full, 1);
    for (int r = 0; r < 10; r++) begin
      ht = exp_head[ROB_SIZE_LOG-1:0];
      do_wb(ht, tag_data[ht], 8'd0);
      @(negedge clk);
      chk("wrap_cv", commit_valid, 1);
      chk("wrap_full_before", full, 1);
      step();
      chk("wrap_full_after_commit", full, 0);
      chk("wrap_empty_after_commit", empty, 0);
      do_alloc(8'(30 + r), 5'(r + 14), 1'b1, 1'b0, 32'h300 + 32'(r), 1'b1);
      chk("wrap_refill_full", full, 1);
    end
    start_head = exp_head;
    for (int k = 0; k < 4; k++) begin
      ht = start_head[ROB_SIZE_LOG-1:0] + 2'(k);
      do_wb(ht, tag_data[ht], 8'd0);
    end
    wait_drain();
    chk("final_empty", empty, 1);
    chk("final_sb_size", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
